// File: rtl/col_vec_gen_pkg.sv
// Shared types for the line-buffer / column-vector stage and the column PE.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package col_vec_gen_pkg;

  // Default geometry; the top module re-parameterises these per instance.
  localparam int unsigned CVG_DATA_W   = 8;
  localparam int unsigned CVG_KERNEL_H = 7;
  localparam int unsigned CVG_IMG_W    = 64;

  typedef logic [CVG_DATA_W-1:0]                   pixel_t;
  typedef logic [CVG_KERNEL_H-1:0][CVG_DATA_W-1:0] vec_t;

  // PRIME: still filling the first KERNEL_H-1 rows. STREAM: one vector per pixel.
  typedef enum logic {
    ST_PRIME  = 1'b0,
    ST_STREAM = 1'b1
  } state_e;

  // Counter/pointer width that never collapses to zero bits.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/col_vec_gen_line.sv
// One image line of pixel storage: single clock, shared read/write address.
// Latency: 1 cycle registered read; read-before-write on a same-address access.
// Backpressure: none; the caller gates both enables with its accept strobe.
// Ports: i_clk; i_rd_en/i_wr_en strobes; i_addr column; i_wr_data in; o_rd_data out.
module line_ram
  import col_vec_gen_pkg::*;
#(
  parameter int unsigned DEPTH  = CVG_IMG_W,
  parameter int unsigned WIDTH  = CVG_DATA_W,
  parameter int unsigned ADDR_W = clog2_min1(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rd_en,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [WIDTH-1:0]  i_wr_data,
  output logic [WIDTH-1:0]  o_rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Non-blocking semantics return the old word when reading and writing one address.
  always_ff @(posedge i_clk) begin
    if (i_rd_en) o_rd_data <= mem[i_addr];
    if (i_wr_en) mem[i_addr] <= i_wr_data;
  end

endmodule

// File: rtl/col_vec_gen.sv
// Raster pixel stream in, KERNEL_H-tall column vectors out (oldest row in element 0).
// Latency: 1 cycle from pixel accept to o_vld with its vector.
// Backpressure: o_rdy = !o_vld || i_rdy (combinational from i_rdy); output holds while stalled.
// Ports: i_clk, i_rst_n (async, active-low); pixel in i_vld/i_eof/i_data/o_rdy;
//        vector out o_vld/o_eof/o_data/i_rdy.
// Option: define COL_VEC_GEN_TOP_PAD_EN to emit from row 0 with missing rows zeroed.
module col_vec_gen
  import col_vec_gen_pkg::*;
#(
  parameter int unsigned DATA_W   = CVG_DATA_W,
  parameter int unsigned KERNEL_H = CVG_KERNEL_H,
  parameter int unsigned IMG_W    = CVG_IMG_W
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_vld,
  input  logic                             i_eof,
  input  logic [DATA_W-1:0]                i_data,
  output logic                             o_rdy,
  input  logic                             i_rdy,
  output logic                             o_vld,
  output logic                             o_eof,
  output logic [KERNEL_H-1:0][DATA_W-1:0]  o_data
);

  localparam int unsigned LINES = KERNEL_H - 1;
  localparam int unsigned COL_W = clog2_min1(IMG_W);
  localparam int unsigned ROW_W = clog2_min1(KERNEL_H);
  localparam int unsigned PTR_W = clog2_min1(LINES);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_FULL = ROW_W'(KERNEL_H - 1);
  localparam logic [ROW_W-1:0] ROW_PRE  = ROW_W'(KERNEL_H - 2);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(LINES - 1);

  logic              accept;
  logic              col_wrap;
  logic              emit;
  logic [COL_W-1:0]  col_cnt;
  logic [ROW_W-1:0]  row_cnt;
  logic [PTR_W-1:0]  row_ptr;
  logic [PTR_W-1:0]  ptr_q;
  logic [DATA_W-1:0] cur_q;
  logic [DATA_W-1:0] rd_data [LINES];
  state_e            state_q;
  state_e            state_d;

  assign o_rdy    = !o_vld || i_rdy;
  assign accept   = i_vld && o_rdy;
  assign col_wrap = (col_cnt == COL_LAST);

  // Raster position. row_ptr names the line holding the oldest row, which is
  // exactly the line the current row overwrites.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      col_cnt <= '0;
      row_cnt <= '0;
      row_ptr <= '0;
    end else if (accept) begin
      if (i_eof) begin
        col_cnt <= '0;
        row_cnt <= '0;
        row_ptr <= '0;
      end else if (col_wrap) begin
        col_cnt <= '0;
        if (row_cnt != ROW_FULL) row_cnt <= row_cnt + ROW_W'(1);
        row_ptr <= (row_ptr == PTR_LAST) ? '0 : row_ptr + PTR_W'(1);
      end else begin
        col_cnt <= col_cnt + COL_W'(1);
      end
    end
  end

  // FSM: state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_PRIME;
    else          state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (accept) begin
      if (i_eof)                              state_d = ST_PRIME;
      else if (col_wrap && row_cnt == ROW_PRE) state_d = ST_STREAM;
    end
  end

  // FSM: output decode
  always_comb begin
`ifdef COL_VEC_GEN_TOP_PAD_EN
    emit = 1'b1;
`else
    emit = (state_q == ST_STREAM);
`endif
  end

  // Output register; reloads on a same-cycle take + accept for full throughput.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_vld <= 1'b0;
      o_eof <= 1'b0;
      cur_q <= '0;
      ptr_q <= '0;
    end else if (accept) begin
      o_vld <= emit;
      o_eof <= emit && i_eof;
      cur_q <= i_data;
      ptr_q <= row_ptr;
    end else if (i_rdy) begin
      o_vld <= 1'b0;
      o_eof <= 1'b0;
    end
  end

`ifdef COL_VEC_GEN_TOP_PAD_EN
  logic [ROW_W-1:0] rowc_q;

  // Rows already buffered when the pixel was accepted; decides which elements are padding.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    rowc_q <= '0;
    else if (accept) rowc_q <= row_cnt;
  end
`endif

  for (genvar g = 0; g < LINES; g++) begin : g_line
    line_ram #(
      .DEPTH (IMG_W),
      .WIDTH (DATA_W)
    ) u_line (
      .i_clk     (i_clk),
      .i_rd_en   (accept),
      .i_wr_en   (accept && (row_ptr == PTR_W'(g))),
      .i_addr    (col_cnt),
      .i_wr_data (i_data),
      .o_rd_data (rd_data[g])
    );
  end

  // Rotate lines oldest-first starting at the captured row pointer. Line RAM
  // contents are never cleared, so the bus is zeroed whenever nothing is valid.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx    = '0;
    o_data = '0;
    if (o_vld) begin
      for (int k = 0; k < int'(LINES); k++) begin
        idx       = PTR_W'((int'(ptr_q) + k) % int'(LINES));
        o_data[k] = rd_data[idx];
`ifdef COL_VEC_GEN_TOP_PAD_EN
        if (k < int'(LINES) - int'(rowc_q)) o_data[k] = '0;
`endif
      end
      o_data[KERNEL_H-1] = cur_q;
    end
  end

endmodule

// File: tb/tb_col_vec_gen.sv
module tb_col_vec_gen;

  localparam int KH = 3;
  localparam int W  = 4;
  localparam int DW = 8;
`ifdef COL_VEC_GEN_TOP_PAD_EN
  localparam int PAD = 1;
`else
  localparam int PAD = 0;
`endif

  typedef logic [KH*DW:0] ent_t;   // {eof, vector}

  logic                  i_clk;
  logic                  i_rst_n;
  logic                  i_vld;
  logic                  i_eof;
  logic [DW-1:0]         i_data;
  logic                  o_rdy;
  logic                  i_rdy;
  logic                  o_vld;
  logic                  o_eof;
  logic [KH-1:0][DW-1:0] o_data;

  ent_t       got_q[$];
  ent_t       exp_q[$];
  logic [7:0] img [16][W];
  int         m_n;
  int         acc_cnt;
  int         checks;
  int         errors;

  col_vec_gen #(.DATA_W(DW), .KERNEL_H(KH), .IMG_W(W)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_vld   (i_vld),
    .i_eof   (i_eof),
    .i_data  (i_data),
    .o_rdy   (o_rdy),
    .i_rdy   (i_rdy),
    .o_vld   (o_vld),
    .o_eof   (o_eof),
    .o_data  (o_data)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1);
  end

  // Record every vector handed over (valid and ready in the same cycle).
  always @(negedge i_clk)
    if (i_rst_n && o_vld && i_rdy) got_q.push_back({o_eof, o_data});

  // Reference: frame position = number of pixels accepted since the last eof.
  task automatic model_accept(input logic [7:0] d, input logic e);
    int r, c, src;
    logic [KH*DW-1:0] v;
    bit do_emit;
    r = m_n / W;
    c = m_n % W;
    if (r < 16) img[r][c] = d;
    do_emit = (PAD != 0) || (r >= KH - 1);
    if (do_emit) begin
      v = '0;
      for (int k = 0; k < KH; k++) begin
        src = r - (KH - 1) + k;
        if (k == KH - 1)               v[k*DW +: DW] = d;
        else if (src >= 0 && src < 16) v[k*DW +: DW] = img[src][c];
      end
      exp_q.push_back({e, v});
    end
    m_n = e ? 0 : m_n + 1;
  endtask

  task automatic send_px(input logic [7:0] d, input logic e);
    bit done;
    done   = 0;
    i_vld  = 1'b1;
    i_data = d;
    i_eof  = e;
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge i_clk);
      if (o_rdy) begin
        model_accept(d, e);
        acc_cnt++;
        done = 1;
      end
    end
    @(posedge i_clk);
    #1;
    i_vld = 1'b0;
    i_eof = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL send_px_timeout: accepted=%0d required=1", done);
    end
  endtask

  task automatic send_rows(input int r0, input int r1, input bit eof_end);
    for (int r = r0; r <= r1; r++)
      for (int c = 0; c < W; c++)
        send_px(8'(16 * r + c), eof_end && r == r1 && c == W - 1);
  endtask

  task automatic drain();
    i_rdy = 1'b1;
    repeat (6) @(posedge i_clk);
    #1;
  endtask

  task automatic clear_q();
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    i_vld   = 1'b0;
    i_eof   = 1'b0;
    i_data  = '0;
    i_rdy   = 1'b1;
    m_n     = 0;
    repeat (2) @(posedge i_clk);
    #1;
    checks++; if (o_vld !== 1'b0)  begin errors++; $display("FAIL reset_o_vld: got %b want 0", o_vld); end
    checks++; if (o_eof !== 1'b0)  begin errors++; $display("FAIL reset_o_eof: got %b want 0", o_eof); end
    checks++; if (o_data !== '0)   begin errors++; $display("FAIL reset_o_data: got %h want 0", o_data); end
    checks++; if (o_rdy !== 1'b1)  begin errors++; $display("FAIL reset_o_rdy: got %b want 1", o_rdy); end
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
  endtask

  task automatic test_prime_stream();
    int n_eof;
    clear_q();
    send_rows(0, 1, 0);
    drain();
    checks++;
    if (got_q.size() !== PAD * 8) begin
      errors++; $display("FAIL prime_no_vld: got %0d vectors want %0d", got_q.size(), PAD * 8);
    end
    send_rows(2, 2, 1);
    drain();
    checks++;
    if (got_q.size() !== (PAD ? 12 : 4)) begin
      errors++; $display("FAIL prime_count: got %0d want %0d", got_q.size(), PAD ? 12 : 4);
    end
    checks++;
    if (got_q.size() > PAD * 8 && got_q[PAD*8] !== 25'h0_201000) begin
      errors++; $display("FAIL vec_2_0: got %h want 0201000", got_q[PAD*8]);
    end
    checks++;
    if (got_q.size() > 0 && got_q[got_q.size()-1] !== 25'h1_231303) begin
      errors++; $display("FAIL vec_eof: got %h want 1231303", got_q[got_q.size()-1]);
    end
    n_eof = 0;
    foreach (got_q[i]) if (got_q[i][KH*DW]) n_eof++;
    checks++;
    if (n_eof !== 1) begin errors++; $display("FAIL eof_count: got %0d want 1", n_eof); end
`ifdef COL_VEC_GEN_TOP_PAD_EN
    checks++;
    if (got_q.size() > 5 && got_q[1] !== 25'h0_010000) begin
      errors++; $display("FAIL pad_vec_0_1: got %h want 0010000", got_q[1]);
    end
    checks++;
    if (got_q.size() > 5 && got_q[5] !== 25'h0_110100) begin
      errors++; $display("FAIL pad_vec_1_1: got %h want 0110100", got_q[5]);
    end
`endif
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL prime_model_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL prime_vec[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_pressure();
    logic [KH*DW-1:0] hold;
    int tgt;
    bit hit;
    clear_q();
    tgt  = acc_cnt + 2 * W + 2;   // just after pixel (2,1) is accepted
    hold = '0;
    hit  = 0;
    fork
      send_rows(0, 2, 1);
      begin
        for (int t = 0; t < 200 && !hit; t++) begin
          @(posedge i_clk);
          if (acc_cnt >= tgt) hit = 1;
        end
        checks++;
        if (!hit) begin errors++; $display("FAIL stall_wait: reached=%0d want 1", hit); end
        #1;
        i_rdy = 1'b0;
        for (int s = 0; s < 5; s++) begin
          @(negedge i_clk);
          if (s == 0) begin
            hold = o_data;
            checks++;
            if (hold !== 24'h211101) begin errors++; $display("FAIL stall_vec_2_1: got %h want 211101", hold); end
          end
          checks++;
          if (o_rdy !== 1'b0 || o_vld !== 1'b1 || o_data !== hold) begin
            errors++;
            $display("FAIL stall_hold[%0d]: got rdy=%b vld=%b data=%h want rdy=0 vld=1 data=%h", s, o_rdy, o_vld, o_data, hold);
          end
        end
        @(posedge i_clk);
        #1;
        i_rdy = 1'b1;
      end
    join
    drain();
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL stall_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL stall_vec[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_row_wrap();
    clear_q();
    send_rows(0, 4, 1);
    drain();
    checks++;
    if (got_q.size() !== (PAD ? 20 : 12)) begin
      errors++; $display("FAIL wrap_count: got %0d want %0d", got_q.size(), PAD ? 20 : 12);
    end
    checks++;
    if (got_q.size() > (PAD ? 17 : 9) && got_q[PAD ? 17 : 9] !== 25'h0_413121) begin
      errors++; $display("FAIL wrap_vec_4_1: got %h want 0413121", got_q[PAD ? 17 : 9]);
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL wrap_vec[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_eof_midframe();
    clear_q();
    send_rows(0, 0, 0);
    send_px(8'h10, 1'b0);
    send_px(8'h11, 1'b0);
    send_px(8'h12, 1'b1);
    drain();
    checks++;
    if (got_q.size() !== PAD * 7 || exp_q.size() !== PAD * 7) begin
      errors++; $display("FAIL eof_mid_count: got %0d want %0d", got_q.size(), PAD * 7);
    end
    clear_q();
    send_rows(0, 2, 1);
    drain();
    checks++;
    if (got_q.size() !== (PAD ? 12 : 4)) begin
      errors++; $display("FAIL eof_next_count: got %0d want %0d", got_q.size(), PAD ? 12 : 4);
    end
    checks++;
    if (got_q.size() > PAD * 8 && got_q[PAD*8] !== 25'h0_201000) begin
      errors++; $display("FAIL eof_next_first: got %h want 0201000", got_q[PAD*8]);
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL eof_next_vec[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    clear_q();
    send_rows(0, 1, 0);
    send_px(8'h20, 1'b0);   // (2,0) now pending on the output
    i_rdy = 1'b0;
    #1;
    i_rst_n = 1'b0;
    #1;
    checks++;
    if (o_vld !== 1'b0 || o_data !== '0 || o_eof !== 1'b0) begin
      errors++; $display("FAIL rst_mid_async: got vld=%b eof=%b data=%h want 0 0 0", o_vld, o_eof, o_data);
    end
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    i_rdy   = 1'b1;
    m_n     = 0;
    clear_q();
    send_rows(0, 2, 1);
    drain();
    checks++;
    if (got_q.size() !== (PAD ? 12 : 4) || got_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL rst_mid_count: got %0d want %0d", got_q.size(), PAD ? 12 : 4);
    end
    checks++;
    if (got_q.size() > PAD * 8 && got_q[PAD*8] !== 25'h0_201000) begin
      errors++; $display("FAIL rst_mid_first: got %h want 0201000", got_q[PAD*8]);
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL rst_mid_vec[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    bit done;
    clear_q();
    done = 0;
    fork
      begin
        for (int f = 0; f < 20; f++) begin
          int rows;
          bit stop;
          rows = $urandom_range(1, 5);
          stop = 0;
          for (int p = 0; p < rows * W && !stop; p++) begin
            bit e;
            e = (p == rows * W - 1) || ($urandom_range(0, 15) == 0);
            send_px(8'($urandom), e);
            stop = e;
            if ($urandom_range(0, 3) == 0) begin
              repeat ($urandom_range(1, 3)) @(posedge i_clk);
              #1;
            end
          end
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge i_clk);
          #1;
          i_rdy = ($urandom_range(0, 2) != 0);
        end
      end
    join
    drain();
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL rand_vec[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    acc_cnt = 0;
    m_n     = 0;
    test_reset();
    test_prime_stream();
    test_back_pressure();
    test_row_wrap();
    test_eof_midframe();
    test_reset_midframe();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/col_vec_gen.md
Name: col_vec_gen

Overview:
- Line-buffer stage directly upstream of the column processing element.
- Converts a raster-order pixel stream (one DATA_W pixel per beat, frame-terminated by i_eof) into KERNEL_H-tall column vectors, one per input pixel once enough rows are buffered.
- Holds KERNEL_H-1 previous image rows in on-chip line memory.
- Presents vectors with a valid/ready/eof handshake matching the column PE input.

Parameters:
- DATA_W, 8: pixel width in bits.
- KERNEL_H, 7: vector height (rows per column vector); must be >= 2.
- IMG_W, 64: pixels per image row; must be >= 2.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, asynchronous assert, active-low.
- i_vld  in  1  input pixel valid.
- i_eof  in  1  input pixel is last of frame; qualified by i_vld.
- i_data  in  DATA_W  input pixel.
- o_rdy  out  1  block accepts a pixel this cycle.
- i_rdy  in  1  downstream ready for a vector.
- o_vld  out  1  o_data/o_eof valid.
- o_eof  out  1  vector is last of frame.
- o_data  out  [KERNEL_H-1:0][DATA_W-1:0]  column vector. Element 0 is the oldest row; element KERNEL_H-1 is the current pixel.

Behaviour:
- Accept condition:
  - accept = i_vld && o_rdy.
  - o_rdy = !o_vld || i_rdy. This is a combinational path from i_rdy, which is intentional because the downstream PE has an input skid buffer.
- Reset (i_rst_n low, asynchronous):
  - Outputs: o_vld=0, o_eof=0, o_data=0.
  - Counters: col_cnt=0, row_cnt=0, row_ptr=0.
  - Line memory contents are not cleared. Row validity is tracked only by row_cnt.
- Counters:
  - col_cnt advances on accept and wraps IMG_W-1 -> 0.
  - On wrap: row_cnt increments, saturating at KERNEL_H-1, and row_ptr advances modulo KERNEL_H-1.
- Line memory:
  - KERNEL_H-1 lines, each IMG_W deep.
  - On accept, all lines are read at col_cnt. The incoming pixel is written into line row_ptr at col_cnt in the same cycle, with read-before-write.
- Vector assembly:
  - Lines are ordered oldest-first starting at line row_ptr, rotating.
  - Element k = pixel at (row - (KERNEL_H-1) + k, col_cnt).
- States:
  - PRIME: row_cnt < KERNEL_H-1. Pixels are accepted and stored; no vector is emitted; o_vld stays 0.
  - STREAM: row_cnt == KERNEL_H-1. Every accepted pixel produces a vector.
  - PRIME -> STREAM on the col_cnt wrap that makes row_cnt reach KERNEL_H-1.
- Latency and hold:
  - Latency is 1 cycle: a pixel accepted at cycle t yields o_vld=1 with its vector at t+1.
  - While o_vld && !i_rdy, o_data, o_eof and o_vld hold stable. No accept occurs and no memory read or write occurs (read enable gated by accept).
  - o_vld clears when the vector is taken (i_rdy) and no new pixel is accepted in the same cycle.
- End of frame (accept with i_eof=1):
  - The produced vector, if any, carries o_eof=1.
  - col_cnt, row_cnt and row_ptr return to 0 at the end of that cycle, and the state returns to PRIME.
  - This applies even when i_eof arrives mid-row; the partial row is discarded.
  - If i_eof is accepted in PRIME, no vector is emitted and the counters still reset.
- Simultaneous take and accept: the output register reloads in the same cycle, giving back-to-back vectors at full throughput.
- Reset mid-frame: any pending vector is lost; the next frame starts in PRIME.

Optional Feature:
- Macro: COL_VEC_GEN_TOP_PAD_EN.
- Defined:
  - Vectors are emitted from row 0 onward; there is no PRIME suppression.
  - Element k is forced to 0 when its source row < 0, i.e. k < (KERNEL_H-1) - row_cnt.
  - Output count per frame equals the input pixel count.
- Undefined:
  - Behaviour as above; output count = (rows - (KERNEL_H-1)) * IMG_W.

Decomposition:
- Shared package: state encoding (PRIME, STREAM) and a pixel typedef of DATA_W bits.
- Add a vector typedef [KERNEL_H-1:0][DATA_W-1:0] to the package, shared with the column PE.
- One sub-module, line_ram:
  - single-clock, IMG_W x DATA_W;
  - read enable and write enable, same address;
  - read-before-write, registered read data;
  - instantiated KERNEL_H-1 times.

Test Plan:
- Bench configuration: KERNEL_H=3, IMG_W=4, pixel value = 16*row + col, i_rdy=1. Send 3 rows, i_eof on pixel (2,3).
  - Required: no o_vld during rows 0-1.
  - Vector for (2,0) = {0x00, 0x10, 0x20} (element 0 first).
  - 4 vectors total; o_eof only on the vector {0x03, 0x13, 0x23}.
- Same stream with i_rdy held low for 5 cycles mid-row 2:
  - o_rdy=0 and o_data stable for those cycles.
  - Vector sequence identical to the previous test; no drops or duplicates.
- 5-row frame:
  - Row-pointer wrap verified: vector at (4,1) = {0x21, 0x31, 0x41}.
- i_eof on pixel (1,2), then a new frame:
  - No vectors are emitted for the first frame.
  - Second frame primes fresh: its first vector appears at its row 2.
- Assert i_rst_n low for one cycle at pixel (2,1):
  - o_vld=0 immediately (asynchronous).
  - Next frame behaves as a fresh frame.
- With COL_VEC_GEN_TOP_PAD_EN:
  - Vector for (0,1) = {0, 0, 0x01}; vector for (1,1) = {0, 0x01, 0x11}.
  - 12 vectors for a 3x4 frame.
